uart_sram_loader: RTL
=====================

// Module: uart_sram_loader
// PURPOSE
//   Parses a framed UART byte stream and writes its payload into external SRAM.
//   Bytes arrive as {data, valid} pulses, one byte per pulse; the same interface is driven by the test stimulus at top level.
//   Bytes are assembled into DATA_W-bit words and issued as sequential SRAM writes.
//   One status byte per frame is returned on the UART TX side.
// PARAMETERS
//   DATA_W      16      SRAM word width; multiple of 8, range 8..32
//   ADDR_W      16      SRAM word address width; AB = ceil(ADDR_W/8) address bytes per frame
//   HDR_BYTE    8'h5A   frame start byte
//   TIMEOUT_CYC 100000  maximum idle cycles between bytes inside a frame
// PORTS
//   i_clk_sys         in   1       system clock
//   i_rst_n           in   1       asynchronous active-low reset
//   i_uart_data       in   8       received byte
//   i_uart_valid      in   1       1-cycle strobe; i_uart_data valid this cycle
//   o_sram_wr_en      out  1       write request; held until accepted
//   o_sram_addr       out  ADDR_W  write word address
//   o_sram_wdata      out  DATA_W  write data
//   i_sram_wr_ready   in   1       SRAM accepts the write when wr_en & ready are both 1
//   o_tx_data         out  8       status byte
//   o_tx_valid        out  1       status valid; held until accepted
//   i_tx_ready        in   1       TX accepts the byte when valid & ready are both 1
//   o_busy            out  1       1 in any state except IDLE
//   o_frame_err       out  1       1-cycle pulse on any frame error
// BEHAVIOUR
//   Clock and reset
//   - One clock domain. All outputs register from i_clk_sys.
//   - Async reset forces state IDLE and clears all outputs, counters and the checksum.
//   - Reset mid-frame discards the frame; no ack byte is sent.
//   Frame format: HDR, ADDR[AB] (MSB first), LEN[2] (word count, MSB first), LEN*DATA_W/8 data bytes (MSB first per word), [CKSUM].
//   States and transitions (IDLE, ADDR, LEN, DATA, CKSUM, DRAIN, ACK)
//   - IDLE: non-HDR bytes are ignored; HDR -> ADDR.
//   - ADDR: after AB bytes -> LEN.
//   - LEN: after 2 bytes -> DATA, or -> CKSUM/DRAIN when LEN=0.
//   - DATA: a word completes on its last byte; it is loaded into the 1-deep holding register and o_sram_wr_en is raised the next cycle.
//       - Address starts at ADDR and increments by 1 per accepted word; it wraps modulo 2^ADDR_W.
//       - Word complete while the holding register is still pending = overrun: o_frame_err pulses, status 0xE1, the word is dropped, state -> DRAIN.
//   - DRAIN: waits until the pending write is accepted -> ACK.
//   - ACK: o_tx_valid=1 with the status byte; on accept -> IDLE.
//       - Bytes received in DRAIN or ACK are dropped silently.
//   Timeout
//   - An inter-byte gap > TIMEOUT_CYC in ADDR/LEN/DATA/CKSUM -> o_frame_err pulses, status 0xE0, -> DRAIN.
//   - The gap counter resets on every i_uart_valid.
//   Status codes: 0xA5 ok, 0xE0 timeout, 0xE1 overrun, 0xEE checksum mismatch.
//   Simultaneous events
//   - A write accept and a new word completing in the same cycle is not an overrun.
//   - i_uart_valid and a timeout in the same cycle: the byte wins.
// CONFIGURATION
//   UART_SRAM_LOADER_CKSUM_EN
//   - Defined: the frame carries a trailing CKSUM byte, the XOR of all bytes after HDR. State CKSUM compares it; match -> 0xA5, else -> 0xEE and o_frame_err pulses. Writes already issued are not rolled back.
//   - Undefined: no CKSUM byte; the last data byte (or the LEN with LEN=0) goes directly to DRAIN; status 0xA5 unless an error occurred.
// TESTING (DATA_W=16, ADDR_W=16, TIMEOUT_CYC=50, CKSUM_EN defined unless noted)
//   1. Bytes 5A 00 10 00 02 12 34 56 78 1A, sram/tx ready=1
//      -> writes (0x0010,0x1234) then (0x0011,0x5678); tx 0xA5; o_busy low afterwards.
//   2. Same frame with CKSUM 0x00 -> both writes issued; tx 0xEE; one o_frame_err pulse.
//   3. Bytes 5A FF FF 00 02 AA BB CC DD (+cksum) -> writes to 0xFFFF then 0x0000 (address wraps); tx 0xA5.
//   4. Bytes 5A 00 10, then a 60-cycle gap -> o_frame_err pulses; tx 0xE0; no writes; a following valid frame is accepted normally.
//   5. i_sram_wr_ready=0, frame with LEN=3 sent back-to-back -> 1st write held, 2nd word overruns; tx 0xE1 after the 1st write is accepted.
//   6. Assert i_rst_n=0 mid-DATA -> all outputs 0 at once; after release, stray data bytes are ignored until a new 5A arrives.
//      Repeat test 1 with CKSUM_EN undefined and the cksum byte omitted -> identical writes, tx 0xA5.

Source files
------------

// File: rtl/uart_sram_loader.sv
// Framed UART byte stream -> sequential SRAM word writes, one status byte back per frame.
// Define UART_SRAM_LOADER_CKSUM_EN to require and verify a trailing XOR checksum byte.
module uart_sram_loader #(
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 16,
    parameter logic [7:0] HDR_BYTE    = 8'h5A,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic [7:0]        i_uart_data,
    input  logic              i_uart_valid,
    output logic              o_sram_wr_en,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic              i_sram_wr_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_frame_err
);
    localparam int AB    = (ADDR_W + 7) / 8;
    localparam int WB    = DATA_W / 8;
    localparam int AA_W  = AB * 8;
    localparam int BC_W  = $clog2((AB > WB ? AB : WB) + 2);
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1) + 1;

    localparam logic [BC_W-1:0]  AB_LAST   = BC_W'(AB - 1);
    localparam logic [BC_W-1:0]  WB_LAST   = BC_W'(WB - 1);
    localparam logic [BC_W-1:0]  LEN_LAST  = BC_W'(1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_ACK   = 3'd6;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_TIMEOUT = 8'hE0;
    localparam logic [7:0] ST_OVERRUN = 8'hE1;
`ifdef UART_SRAM_LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM    = 3'd4;
    localparam logic [2:0] S_TAIL     = S_CKSUM;
    localparam logic [7:0] ST_CKSUM   = 8'hEE;
`else
    localparam logic [2:0] S_TAIL     = S_DRAIN;
`endif

    logic [2:0]        state_q, state_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;
    logic [AA_W-1:0]   addr_acc_q, addr_acc_d;
    logic [15:0]       len_q, len_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        status_q, status_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef UART_SRAM_LOADER_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    logic [DATA_W-1:0] word_sh;
    logic [AA_W-1:0]   addr_sh;
    logic [15:0]       len_sh;
    logic              timed;
    logic              timeout;

    assign word_sh = (word_q << 8) | DATA_W'(i_uart_data);
    assign addr_sh = (addr_acc_q << 8) | AA_W'(i_uart_data);
    assign len_sh  = (len_q << 8) | 16'(i_uart_data);

    always_comb begin
        timed = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA);
`ifdef UART_SRAM_LOADER_CKSUM_EN
        timed = timed || (state_q == S_CKSUM);
`endif
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = timed && !i_uart_valid && (gap_q >= GAP_LIMIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_acc_d  = addr_acc_q;
        len_d       = len_q;
        word_d      = word_q;
        wr_en_d     = wr_en_q && !i_sram_wr_ready;
        sram_addr_d = sram_addr_q;
        wdata_d     = wdata_q;
        tx_valid_d  = tx_valid_q;
        status_d    = status_q;
        err_d       = 1'b0;

        if (!timed || i_uart_valid) begin
            gap_d = '0;
        end else if (gap_q < GAP_LIMIT) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end

`ifdef UART_SRAM_LOADER_CKSUM_EN
        if (state_q == S_IDLE) begin
            cksum_d = '0;
        end else if (timed && i_uart_valid) begin
            cksum_d = cksum_q ^ i_uart_data;
        end else begin
            cksum_d = cksum_q;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (i_uart_valid && i_uart_data == HDR_BYTE) begin
                    state_d  = S_ADDR;
                    cnt_d    = '0;
                    status_d = ST_OK;
                end
            end
            S_ADDR: begin
                if (i_uart_valid) begin
                    addr_acc_d = addr_sh;
                    if (cnt_q == AB_LAST) begin
                        state_d = S_LEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BC_W'(1);
                    end
                end
            end
            S_LEN: begin
                if (i_uart_valid) begin
                    len_d = len_sh;
                    if (cnt_q == LEN_LAST) begin
                        cnt_d   = '0;
                        state_d = (len_sh == 16'd0) ? S_TAIL : S_DATA;
                    end else begin
                        cnt_d = cnt_q + BC_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_uart_valid) begin
                    if (cnt_q != WB_LAST) begin
                        word_d = word_sh;
                        cnt_d  = cnt_q + BC_W'(1);
                    end else if (wr_en_q && !i_sram_wr_ready) begin
                        // Holding register still occupied: drop this word and abort.
                        cnt_d    = '0;
                        state_d  = S_DRAIN;
                        status_d = ST_OVERRUN;
                        err_d    = 1'b1;
                    end else begin
                        cnt_d       = '0;
                        wr_en_d     = 1'b1;
                        sram_addr_d = addr_acc_q[ADDR_W-1:0];
                        wdata_d     = word_sh;
                        addr_acc_d  = addr_acc_q + AA_W'(1);
                        len_d       = len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            state_d = S_TAIL;
                        end
                    end
                end
            end
`ifdef UART_SRAM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (i_uart_valid) begin
                    state_d = S_DRAIN;
                    if (i_uart_data != cksum_q) begin
                        status_d = ST_CKSUM;
                        err_d    = 1'b1;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (!wr_en_q || i_sram_wr_ready) begin
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                end
            end
            S_ACK: begin
                if (i_tx_ready) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d  = S_DRAIN;
            status_d = ST_TIMEOUT;
            err_d    = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_acc_q  <= '0;
            len_q       <= '0;
            word_q      <= '0;
            gap_q       <= '0;
            wr_en_q     <= 1'b0;
            sram_addr_q <= '0;
            wdata_q     <= '0;
            tx_valid_q  <= 1'b0;
            status_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef UART_SRAM_LOADER_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_acc_q  <= addr_acc_d;
            len_q       <= len_d;
            word_q      <= word_d;
            gap_q       <= gap_d;
            wr_en_q     <= wr_en_d;
            sram_addr_q <= sram_addr_d;
            wdata_q     <= wdata_d;
            tx_valid_q  <= tx_valid_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef UART_SRAM_LOADER_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign o_sram_wr_en = wr_en_q;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_wdata = wdata_q;
    assign o_tx_data    = status_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_busy       = busy_q;
    assign o_frame_err  = err_q;

endmodule
